alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU.
- Keeps the existing 4-bit ALUOp encoding for AND/OR/ADD/SUB/SLT(unsigned)/NOR, and adds shifts, XOR, signed compare, and iterative multiply/divide.
- Sits in the execute stage behind a valid/ready handshake on both input and output, so the controller can stall on multi-cycle operations.
- Result and Zero flag are registered and held until consumed.

Parameters:
- WIDTH, 32: operand/result width in bits; must be ≥ 4 and a power of two.
- MULDIV_EN, 1: 1 builds the iterative multiply/divide unit; 0 makes ops 10, 11, 13, 14 return 0 with single-cycle latency.
- SHW (localparam), $clog2(WIDTH): shift-amount width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept; high only in IDLE
- data_in1  in  WIDTH  operand A
- data_in2  in  WIDTH  operand B / shift amount
- ALUOp  in  4  operation select
- out_valid  out  1  ALUOutput/Zero valid
- out_ready  in  1  consumer accepts result
- ALUOutput  out  WIDTH  registered result
- Zero  out  1  registered (ALUOutput == 0)
- busy  out  1  high in CALC state

Behaviour:
- Reset (synchronous, rst high at rising edge):
  - state=IDLE, in_ready=1 (from the following cycle), out_valid=0, ALUOutput=0, Zero=1, busy=0.
  - Internal acc/quotient/counter cleared.
  - Any operation in flight is abandoned with no output.
- Accept: in_valid & in_ready at an edge captures data_in1, data_in2, ALUOp. Inputs are ignored at all other times.
- Op encoding (A=data_in1, B=data_in2, sh=B[SHW-1:0]):
  - 0: A&B
  - 1: A|B
  - 2: A+B (wraps mod 2^WIDTH)
  - 3: A<<sh
  - 4: A>>sh (logical)
  - 5: A>>>sh (arithmetic)
  - 6: A-B (wraps)
  - 7: unsigned A<B ? 1 : 0
  - 8: signed A<B ? 1 : 0
  - 9: A^B
  - 10: MUL, low WIDTH bits of A*B
  - 11: MULHU, high WIDTH bits of unsigned A*B
  - 12: ~(A|B)
  - 13: DIVU, unsigned A/B
  - 14: REMU, unsigned A%B
  - 15: result 0
- FSM states: IDLE, CALC, DONE.
  - IDLE: accept with a single-cycle op → DONE, result registered at the same edge; out_valid=1 in the next cycle (latency 1).
  - IDLE: accept with op 10/11/13/14 and MULDIV_EN=1 → CALC, counter=WIDTH.
  - CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle; counter decrements. When counter reaches 1, the last step is done and the state goes to DONE. out_valid asserts exactly WIDTH+1 cycles after the accept edge.
  - DONE: out_valid=1, ALUOutput/Zero stable. out_ready high at an edge → IDLE, out_valid=0.
  - in_ready=1 only in IDLE, so there is no back-to-back overlap: a new accept is possible in the cycle after the result is consumed.
- Divide by zero (B=0): DIVU returns all ones; REMU returns A. Still takes WIDTH+1 cycles, no special flag.
- Zero is computed from the value being registered into ALUOutput, never combinationally from a live input.
- out_valid held with out_ready low: outputs must not change for any input activity.
- rst asserted in CALC or DONE: next cycle is IDLE with reset values; out_valid never pulses for the abandoned op.
- MULDIV_EN=0: ops 10/11/13/14 take the IDLE→DONE path with result 0, Zero=1.

Test Plan:
- Reset then ALUOp=2, A=32'hFFFFFFFF, B=1 → out_valid 1 cycle after accept, ALUOutput=0, Zero=1. ALUOp=8, A=32'hFFFFFFFE (-2), B=1 → 1. ALUOp=7 with the same operands → 0.
- ALUOp=5, A=32'h80000000, B=32'h24 (sh=4) → 32'hF8000000. ALUOp=4 with the same operands → 32'h08000000. ALUOp=3, A=1, B=31 → 32'h80000000.
- ALUOp=10, A=32'h12345678, B=32'h10 → out_valid exactly 33 cycles after accept, result 32'h23456780. ALUOp=11, A=B=32'hFFFFFFFF → 32'hFFFFFFFE.
- ALUOp=13, A=100, B=7 → 14. ALUOp=14 with the same operands → 2. ALUOp=13, A=5, B=0 → 32'hFFFFFFFF. ALUOp=14, A=5, B=0 → 5. in_ready=0 and busy=1 throughout CALC.
- Hold out_ready=0 for 10 cycles after a result while toggling in_valid and operands → outputs unchanged, in_ready=0, no second accept. Raise out_ready → IDLE next cycle, in_ready=1.
- Assert rst for 1 cycle mid-DIVU (cycle 10 of CALC) → next cycle IDLE, out_valid=0, ALUOutput=0, Zero=1. A subsequent ALUOp=0, A=32'hF0F0, B=32'hFF00 → 32'hF000.

Source files
------------

// File: rtl/alu_seq_if.sv
// Execute-stage ALU handshake bundle: operand/op request channel plus result channel.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in1;
  logic [WIDTH-1:0] data_in2;
  logic [3:0]       ALUOp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUOutput;
  logic             Zero;
  logic             busy;

  // Controller side: issues operations and consumes results.
  modport master (
    output in_valid,
    output data_in1,
    output data_in2,
    output ALUOp,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  ALUOutput,
    input  Zero,
    input  busy
  );

  // ALU side.
  modport slave (
    input  in_valid,
    input  data_in1,
    input  data_in2,
    input  ALUOp,
    input  out_ready,
    output in_ready,
    output out_valid,
    output ALUOutput,
    output Zero,
    output busy
  );

endinterface

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with valid/ready handshakes. Single-cycle ops finish at the
// accept edge; MUL/MULHU/DIVU/REMU iterate one bit per cycle (shift-add / restoring divide).
module alu_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MULDIV_EN = 1'b1
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OpAnd   = 4'd0;
  localparam logic [3:0] OpOr    = 4'd1;
  localparam logic [3:0] OpAdd   = 4'd2;
  localparam logic [3:0] OpSll   = 4'd3;
  localparam logic [3:0] OpSrl   = 4'd4;
  localparam logic [3:0] OpSra   = 4'd5;
  localparam logic [3:0] OpSub   = 4'd6;
  localparam logic [3:0] OpSltu  = 4'd7;
  localparam logic [3:0] OpSlt   = 4'd8;
  localparam logic [3:0] OpXor   = 4'd9;
  localparam logic [3:0] OpMul   = 4'd10;
  localparam logic [3:0] OpMulhu = 4'd11;
  localparam logic [3:0] OpNor   = 4'd12;
  localparam logic [3:0] OpDivu  = 4'd13;
  localparam logic [3:0] OpRemu  = 4'd14;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [3:0]       op_q, op_d;
  // Multiplicand (mul) or divisor (div).
  logic [WIDTH-1:0] opnd_q, opnd_d;
  // High product half (mul) or partial remainder (div).
  logic [WIDTH-1:0] acc_q, acc_d;
  // Multiplier shifting out / low product (mul), or dividend shifting out / quotient (div).
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;
  logic             in_is_muldiv;
  logic             in_is_mul;
  logic             calc_is_mul;
  logic             calc_hi_sel;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] step_res;

  assign sh = bus.data_in2[SHW-1:0];

  assign in_is_mul    = (bus.ALUOp == OpMul) || (bus.ALUOp == OpMulhu);
  assign in_is_muldiv = MULDIV_EN &&
                        (in_is_mul || (bus.ALUOp == OpDivu) || (bus.ALUOp == OpRemu));
  assign calc_is_mul  = (op_q == OpMul) || (op_q == OpMulhu);
  // MULHU takes the high product half, REMU the remainder; both live in acc.
  assign calc_hi_sel  = (op_q == OpMulhu) || (op_q == OpRemu);

  // Single-cycle result straight from the live operands; only used at the accept edge.
  always_comb begin
    alu_res = '0;
    case (bus.ALUOp)
      OpAnd:   alu_res = bus.data_in1 & bus.data_in2;
      OpOr:    alu_res = bus.data_in1 | bus.data_in2;
      OpAdd:   alu_res = bus.data_in1 + bus.data_in2;
      OpSll:   alu_res = bus.data_in1 << sh;
      OpSrl:   alu_res = bus.data_in1 >> sh;
      OpSra:   alu_res = $unsigned($signed(bus.data_in1) >>> sh);
      OpSub:   alu_res = bus.data_in1 - bus.data_in2;
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (bus.data_in1 < bus.data_in2)};
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.data_in1) < $signed(bus.data_in2))};
      OpXor:   alu_res = bus.data_in1 ^ bus.data_in2;
      OpNor:   alu_res = ~(bus.data_in1 | bus.data_in2);
      // MUL/DIV with the unit absent, and op 15, return zero.
      default: alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply and restoring shift-subtract divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, quo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    // Divisor 0 always "fits": quotient fills with ones and the remainder becomes the dividend.
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (calc_is_mul) begin
      step_acc = mul_sum[WIDTH:1];
      step_quo = {mul_sum[0], quo_q[WIDTH-1:1]};
    end else begin
      step_acc = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], div_ge};
    end
    step_res = calc_hi_sel ? step_acc : step_quo;
  end

  // Next-state and datapath update for the IDLE/CALC/DONE controller.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_d = bus.ALUOp;
          if (in_is_muldiv) begin
            state_d = StCalc;
            opnd_d  = in_is_mul ? bus.data_in1 : bus.data_in2;
            quo_d   = in_is_mul ? bus.data_in2 : bus.data_in1;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end
      end
      StCalc: begin
        acc_d = step_acc;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        // Count 1 means this edge performs the final step; latch its result directly.
        if (cnt_q == CW'(1)) begin
          state_d  = StDone;
          result_d = step_res;
          zero_d   = (step_res == '0);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b1;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q == StCalc);
  assign bus.ALUOutput = result_q;
  assign bus.Zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table over all op classes plus hold, reset-abort and
// MULDIV_EN=0 sequences.
module tb_alu_seq;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq_if #(.WIDTH(32)) bus0 ();

  alu_seq #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_seq #(.WIDTH(32), .MULDIV_EN(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    bus.ALUOp    = op;
    bus.data_in1 = a;
    bus.data_in2 = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Latency counts the accept cycle as 1; calc_ok tracks busy=1/in_ready=0 while waiting.
  task automatic wait_out(output int lat, output bit calc_ok);
    lat     = 0;
    calc_ok = 1'b1;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (!bus.busy || bus.in_ready) calc_ok = 1'b0;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_after_consume", {31'd0, bus.out_valid}, 32'd0);
    check("in_ready_after_consume", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int          lat;
    bit          calc_ok;
    bit          hold_ok;
    bit          no_pulse;
    logic [31:0] held;

    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.ALUOp = '0;
    bus.data_in1 = '0;   bus.data_in2 = '0;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.ALUOp = '0;
    bus0.data_in1 = '0;   bus0.data_in2 = '0;

    vecs[0]  = '{4'd2,  32'hFFFFFFFF, 32'h1,        32'h0,        1};
    vecs[1]  = '{4'd8,  32'hFFFFFFFE, 32'h1,        32'h1,        1};
    vecs[2]  = '{4'd7,  32'hFFFFFFFE, 32'h1,        32'h0,        1};
    vecs[3]  = '{4'd5,  32'h80000000, 32'h24,       32'hF8000000, 1};
    vecs[4]  = '{4'd4,  32'h80000000, 32'h24,       32'h08000000, 1};
    vecs[5]  = '{4'd3,  32'h1,        32'd31,       32'h80000000, 1};
    vecs[6]  = '{4'd10, 32'h12345678, 32'h10,       32'h23456780, 33};
    vecs[7]  = '{4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[8]  = '{4'd13, 32'd100,      32'd7,        32'd14,       33};
    vecs[9]  = '{4'd14, 32'd100,      32'd7,        32'd2,        33};
    vecs[10] = '{4'd13, 32'd5,        32'd0,        32'hFFFFFFFF, 33};
    vecs[11] = '{4'd14, 32'd5,        32'd0,        32'd5,        33};
    vecs[12] = '{4'd0,  32'hF0F0,     32'hFF00,     32'hF000,     1};
    vecs[13] = '{4'd1,  32'hF0F0,     32'hFF00,     32'hFFF0,     1};
    vecs[14] = '{4'd6,  32'd3,        32'd5,        32'hFFFFFFFE, 1};
    vecs[15] = '{4'd9,  32'hF0F0,     32'hFF00,     32'h0FF0,     1};
    vecs[16] = '{4'd12, 32'hF0F0,     32'hFF00,     32'hFFFF000F, 1};
    vecs[17] = '{4'd15, 32'h1234,     32'h5678,     32'h0,        1};
    vecs[18] = '{4'd8,  32'h1,        32'hFFFFFFFE, 32'h0,        1};
    vecs[19] = '{4'd7,  32'h1,        32'hFFFFFFFE, 32'h1,        1};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_result", bus.ALUOutput, 32'd0);
    check("reset_zero", {31'd0, bus.Zero}, 32'd1);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_out(lat, calc_ok);
      check($sformatf("v%0d_result", i), bus.ALUOutput, vecs[i].exp);
      check($sformatf("v%0d_zero", i), {31'd0, bus.Zero}, {31'd0, (vecs[i].exp == 32'd0)});
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      if (vecs[i].lat > 1) check($sformatf("v%0d_calc_busy", i), {31'd0, calc_ok}, 32'd1);
      consume();
    end

    // Result held while out_ready stays low, regardless of input activity.
    issue(4'd9, 32'h1234, 32'hFFFF);
    wait_out(lat, calc_ok);
    held    = 32'h0000EDCB;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.ALUOp    = 4'(i);
      bus.data_in1 = $urandom;
      bus.data_in2 = $urandom;
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || bus.busy || bus.Zero || bus.ALUOutput !== held)
        hold_ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    check("hold_result", bus.ALUOutput, held);
    check("hold_stable", {31'd0, hold_ok}, 32'd1);
    consume();

    // Reset in the middle of a divide abandons it silently.
    issue(4'd13, 32'hFFFFFFFF, 32'd3);
    repeat (10) @(negedge clk);
    check("mid_calc_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_result", bus.ALUOutput, 32'd0);
    check("abort_zero", {31'd0, bus.Zero}, 32'd1);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    no_pulse = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid || !bus.in_ready) no_pulse = 1'b0;
    end
    check("abort_no_output", {31'd0, no_pulse}, 32'd1);
    issue(4'd0, 32'hF0F0, 32'hFF00);
    wait_out(lat, calc_ok);
    check("after_abort_and", bus.ALUOutput, 32'hF000);
    check("after_abort_latency", lat, 1);
    consume();

    // Without the mul/div unit, MUL returns 0 in one cycle.
    @(negedge clk);
    bus0.ALUOp    = 4'd10;
    bus0.data_in1 = 32'd3;
    bus0.data_in2 = 32'd5;
    bus0.in_valid = 1'b1;
    @(posedge clk);
    #1 bus0.in_valid = 1'b0;
    @(negedge clk);
    check("nomd_out_valid", {31'd0, bus0.out_valid}, 32'd1);
    check("nomd_result", bus0.ALUOutput, 32'd0);
    check("nomd_zero", {31'd0, bus0.Zero}, 32'd1);
    check("nomd_busy", {31'd0, bus0.busy}, 32'd0);
    bus0.out_ready = 1'b1;
    @(posedge clk);
    #1 bus0.out_ready = 1'b0;
    @(negedge clk);
    check("nomd_in_ready", {31'd0, bus0.in_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
